// File: rtl/add_sub_pkg.sv
// Shared definitions for the serial add/subtract unit: opcodes, FSM states
// and small opcode decode helpers.
// Latency: n/a (package). Backpressure: n/a (package).
package add_sub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Subtraction is A + ~B + cin, so these opcodes store B inverted.
    function automatic logic op_is_sub(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    // Carry-chained opcodes take their initial carry from the stored flag.
    function automatic logic op_uses_cflag(input logic [1:0] op);
        return (op == OP_ADC) || (op == OP_SBB);
    endfunction

endpackage

// File: rtl/add_sub_slice.sv
// SLICE-bit combinational ripple adder used once per clock by the serial unit.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of its inputs.
//
// Ports: a_sl/b_sl operand slices, cin carry in, sum_sl slice sum, cout carry out.
module add_sub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_sl,
    input  logic [SLICE-1:0] b_sl,
    input  logic             cin,
    output logic [SLICE-1:0] sum_sl,
    output logic             cout
);

    assign {cout, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/add_sub_serial_seq.sv
// Serial N-bit add/sub/adc/sbb unit, one SLICE-bit slice per clock, LSB first.
// Latency: handshake cycle T -> out_valid in cycle T+NUM_SLICES+1.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports: clk/rst (sync, active-high); in_valid/in_ready with a_in, b_in,
// opcode; out_valid/out_ready with result_out, carry_out, overflow_out,
// zero_out. cflag carries the last completed operation's carry into ADC/SBB.
module add_sub_serial_seq
    import add_sub_pkg::*;
#(
    parameter int N     = 16,
    parameter int SLICE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [1:0]   opcode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result_out,
    output logic         carry_out,
    output logic         overflow_out,
    output logic         zero_out
);

    localparam int NUM_SLICES = N / SLICE;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_t           state;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;      // already inverted for SUB/SBB
    logic [N-1:0]     res_q;
    logic             carry_q;  // ripple carry between slices
    logic [IDX_W-1:0] idx;
    logic             cflag;

    int               base;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] sum_sl;
    logic             cout;
    logic [N-1:0]     res_next;
    logic             ov_next;

    always_comb begin
        base = int'(idx) * SLICE;
    end

    assign a_sl = a_q[base +: SLICE];
    assign b_sl = b_q[base +: SLICE];

    add_sub_slice #(.SLICE(SLICE)) u_slice (
        .a_sl   (a_sl),
        .b_sl   (b_sl),
        .cin    (carry_q),
        .sum_sl (sum_sl),
        .cout   (cout)
    );

    // Result with the current slice merged in; on the last slice this is the
    // complete word, which lets the flags be registered on entry to DONE.
    always_comb begin
        res_next              = res_q;
        res_next[base +: SLICE] = sum_sl;
    end

    assign ov_next = (a_q[N-1] == b_q[N-1]) && (res_next[N-1] != a_q[N-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            result_out   <= '0;
            carry_out    <= 1'b0;
            overflow_out <= 1'b0;
            zero_out     <= 1'b0;
            cflag        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            carry_q      <= 1'b0;
            idx          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a_in;
                        b_q      <= op_is_sub(opcode) ? ~b_in : b_in;
                        carry_q  <= op_uses_cflag(opcode) ? cflag : op_is_sub(opcode);
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    res_q   <= res_next;
                    carry_q <= cout;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        result_out   <= res_next;
                        carry_out    <= cout;
                        overflow_out <= ov_next;
                        zero_out     <= ~|res_next;
                        cflag        <= cout;
                        out_valid    <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // No same-cycle turnaround: in_ready rises only once IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/add_sub_serial_seq.md
Name: add_sub_serial_seq

Overview:
Parametrised, multi-cycle add/subtract unit that processes N-bit operands in SLICE-bit slices, LSB slice first, one slice per clock. A ripple-carry register links the slices. Carry-chained opcodes (ADC/SBB) let software build wider arithmetic, and status flags are produced per operation. Valid/ready handshakes on both input and output let it sit between an operand-fetch stage and a result writeback stage of the datapath.

Parameters:
N, 16, operand/result width in bits; must be a multiple of SLICE.
SLICE, 4, bits processed per clock; N/SLICE = NUM_SLICES (>=1).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, synchronous, active-high.
in_valid  input  1  operands/opcode valid.
in_ready  output  1  unit can accept an operation.
a_in  input  N  operand A.
b_in  input  N  operand B.
opcode  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBB.
out_valid  output  1  result and flags valid.
out_ready  input  1  downstream accepts result.
result_out  output  N  sum/difference.
carry_out  output  1  carry out of MSB (SUB/SBB: 1 = no borrow).
overflow_out  output  1  signed two's-complement overflow.
zero_out  output  1  result_out == 0.

Behaviour:
- One clock (clk); reset synchronous active-high (rst). rst dominates all other inputs in any state.
- Reset values:
  - in_ready = 1; out_valid = 0.
  - result_out, carry_out, overflow_out and zero_out = 0.
  - Internal stored carry flag (cflag) = 0; FSM = IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch a_in, b_in and opcode, and go to BUSY.
  - B is stored as ~b_in for SUB/SBB, and as b_in otherwise.
  - Initial slice carry: ADD 0, SUB 1, ADC cflag, SBB cflag.
  - Slice index = 0.
- BUSY:
  - in_ready = 0.
  - Each cycle: {c, s} = A[idx] + B[idx] + c, where SLICE+1 bits are used; s is written into result slice idx, and idx increments.
  - After slice NUM_SLICES-1, go to DONE.
  - Latency: handshake at cycle T -> out_valid first high at T+NUM_SLICES+1 (16/4 -> 5 cycles).
- DONE:
  - out_valid = 1; outputs stable and held until out_ready.
  - carry_out = final slice carry.
  - overflow_out = (A[N-1] == Bstored[N-1]) && (result[N-1] != A[N-1]).
  - zero_out = ~|result.
  - cflag <= carry_out on entry to DONE.
  - On out_ready: out_valid drops the next cycle and the FSM goes to IDLE. No same-cycle turnaround: in_ready stays low in DONE.
- result_out and the flags keep their last values while in IDLE/BUSY; only DONE qualifies them.
- in_valid outside IDLE is ignored (upstream must hold it). Operands changing during BUSY have no effect.
- out_ready while not DONE is ignored.
- NUM_SLICES = 1 is legal: BUSY lasts one cycle.
- Wrap-around: results are modulo 2^N. Carry is reported, never saturated.
- cflag persists across operations. It is cleared only by rst, and is updated only by completed operations.
- rst mid-BUSY or in DONE: the operation is discarded, no output handshake occurs, and all reset values are restored (cflag = 0).

Decomposition:
- Shared package add_sub_pkg:
  - opcode localparams: OP_ADD, OP_SUB, OP_ADC, OP_SBB.
  - FSM state encodings: ST_IDLE, ST_BUSY, ST_DONE.
- One natural sub-module: add_sub_slice. It is a combinational SLICE-bit adder with a_sl, b_sl and cin, producing sum_sl and cout.
- The top-level holds the FSM, the operand/result registers, the slice mux/demux and the flag logic.

Test Plan:
- Reset, then ADD 0x1234 + 0x0FCD (N=16, SLICE=4) -> out_valid at handshake+5; result 0x2201, carry 0, overflow 0, zero 0.
- ADD 0xFFFF + 0x0001 -> result 0x0000, carry 1, zero 1, overflow 0. Next, ADC 0x0000 + 0x0000 -> result 0x0001, carry 0.
- SUB 0x0005 - 0x0007 -> result 0xFFFE, carry 0 (borrow), overflow 0. SUB 0x8000 - 0x0001 -> result 0x7FFF, carry 1, overflow 1.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> outputs stable, in_ready = 0, and a new in_valid is not accepted. Release -> IDLE the cycle after the out_ready handshake.
- Assert rst for one cycle during BUSY slice 2 -> next cycle in_ready = 1, out_valid = 0, outputs 0. A following ADC 0x0001 + 0x0001 gives 0x0002 (cflag cleared).
- Parameter sweep with N=32/SLICE=8 and N=8/SLICE=8 -> 1000 random ops per opcode match the reference-model sum/flags; latency is NUM_SLICES+1.
